// File: rtl/gshare_predictor.sv
// Gshare direction predictor: 2-bit counter table indexed by PC (optionally XOR global history).
// Define GSHARE_HASH_EN to hash the GHR into the index; otherwise the table is indexed bimodally.
module gshare_predictor #(
   parameter int PHT_IDX   = 8,
   parameter int GHR_WIDTH = 8,
   parameter int PC_LSB    = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 pred_valid_i,
   input  logic [31:0]          pred_pc_i,
   output logic                 pred_taken_o,
   output logic [PHT_IDX-1:0]   pred_idx_o,
   output logic [GHR_WIDTH-1:0] pred_ghr_o,
   input  logic                 upd_valid_i,
   input  logic [PHT_IDX-1:0]   upd_idx_i,
   input  logic [GHR_WIDTH-1:0] upd_ghr_i,
   input  logic                 upd_taken_i,
   input  logic                 upd_mispredict_i,
   output logic                 cor_o,
   output logic                 cor_valid_o
);

   localparam int ENTRIES = 1 << PHT_IDX;

   logic [1:0]           pht_q [ENTRIES];
   logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
   logic [PHT_IDX-1:0]   pc_bits_s, idx_s;
   logic [1:0]           upd_old_s, upd_cnt_d;
   logic                 cor_q, cor_d, cor_valid_q;
   logic                 unused_pc_s;

   function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
      logic [1:0] r;
      if (taken) begin
         r = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
      end else begin
         r = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
      end
      return r;
   endfunction

   assign pc_bits_s   = pred_pc_i[PC_LSB+PHT_IDX-1:PC_LSB];
   assign unused_pc_s = ^{pred_pc_i[31:PC_LSB+PHT_IDX], pred_pc_i[PC_LSB-1:0]};

`ifdef GSHARE_HASH_EN
   assign idx_s = pc_bits_s ^ PHT_IDX'(ghr_q);
`else
   assign idx_s = pc_bits_s;
`endif

   // Reads see the pre-update table, so same-index read/write returns the old counter.
   assign pred_idx_o   = idx_s;
   assign pred_taken_o = pht_q[idx_s][1];
   assign pred_ghr_o   = ghr_q;
   assign cor_o        = cor_q;
   assign cor_valid_o  = cor_valid_q;

   // Next-state for history, resolved counter and correctness flag.
   always_comb begin
      ghr_d     = ghr_q;
      upd_old_s = pht_q[upd_idx_i];
      upd_cnt_d = sat_step(upd_old_s, upd_taken_i);
      cor_d     = 1'b0;
      if (upd_valid_i && upd_mispredict_i) begin
         ghr_d = {upd_ghr_i[GHR_WIDTH-2:0], upd_taken_i};
      end else if (pred_valid_i) begin
         ghr_d = {ghr_q[GHR_WIDTH-2:0], pred_taken_o};
      end else begin
         ghr_d = ghr_q;
      end
      if (upd_valid_i) begin
         cor_d = (upd_old_s[1] == upd_taken_i);
      end else begin
         cor_d = 1'b0;
      end
   end

   // State registers: history, counter table and the registered chooser outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ghr_q       <= '0;
         cor_q       <= 1'b0;
         cor_valid_q <= 1'b0;
         for (int i = 0; i < ENTRIES; i++) begin
            pht_q[i] <= 2'b01;
         end
      end else begin
         ghr_q       <= ghr_d;
         cor_q       <= cor_d;
         cor_valid_q <= upd_valid_i;
         if (upd_valid_i) begin
            pht_q[upd_idx_i] <= upd_cnt_d;
         end
      end
   end

endmodule
